// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default sizing for the UART transmit arbiter
package uart_pkg;
  localparam int DBIT_DEFAULT = 8;
  localparam int FRAME_MAX_DEFAULT = 64;
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT
`ifdef UART_TX_CHECKSUM_EN
    , CHK,
    CHK_WAIT
`endif
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-stream handshake of the two requesters feeding the arbiter
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int DBIT = DBIT_DEFAULT
);
  logic            req0_valid;
  logic [DBIT-1:0] req0_data;
  logic            req0_last;
  logic            req0_ready;
  logic            req1_valid;
  logic [DBIT-1:0] req1_data;
  logic            req1_last;
  logic            req1_ready;
  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    input  req0_ready, req1_ready
  );
  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on a tie the requester not served last wins
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);
  // a lone request wins outright, a tie goes away from the last-served side
  always_comb gnt = &req ? (last_served ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin sharing of one UART transmitter; UART_TX_CHECKSUM_EN appends an XOR byte per frame
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int DBIT      = DBIT_DEFAULT,
  parameter int FRAME_MAX = FRAME_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            uart_reset_n,
  uart_tx_arbiter_if.slave bus,
  output logic [DBIT-1:0] dataToSend,
  output logic            uart_tx_start,
  input  logic            uart_tx_done,
  output logic [1:0]      grant,
  output logic            busy
);
  state_t          state, state_nx;
  logic            owner, last_served, last_q;
  logic            own_valid, own_last, accept, frame_end, release_grant;
  logic [1:0]      arb;
  logic [7:0]      count;
  logic [DBIT-1:0] data_q, own_data;
`ifdef UART_TX_CHECKSUM_EN
  logic [DBIT-1:0] chk;
`endif

  rr_arbiter2 u_rr (
    .req({bus.req1_valid, bus.req0_valid}),
    .last_served(last_served),
    .gnt(arb)
  );

  // select the frame owner's stream and decode byte acceptance / frame end
  always_comb begin
    own_valid = owner ? bus.req1_valid : bus.req0_valid;
    own_data  = owner ? bus.req1_data : bus.req0_data;
    own_last  = owner ? bus.req1_last : bus.req0_last;
    accept    = state == SEND && own_valid;
    frame_end = state == WAIT && uart_tx_done && (last_q || count == 8'(FRAME_MAX));
  end

  // state register; reset abandons any frame in flight
  always_ff @(posedge clk or negedge uart_reset_n)
    if (!uart_reset_n) state <= IDLE;
    else state <= state_nx;

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = |arb ? SEND : IDLE;
      SEND:     state_nx = own_valid ? WAIT : SEND;
`ifdef UART_TX_CHECKSUM_EN
      WAIT:     state_nx = !uart_tx_done ? WAIT : frame_end ? CHK : SEND;
      CHK:      state_nx = CHK_WAIT;
      CHK_WAIT: state_nx = uart_tx_done ? IDLE : CHK_WAIT;
`else
      WAIT:     state_nx = !uart_tx_done ? WAIT : frame_end ? IDLE : SEND;
`endif
      default:  state_nx = IDLE;
    endcase
  end

  // outputs: ready and start pulse in the accepting cycle, byte passed through until registered
  always_comb begin
    busy           = state != IDLE;
    bus.req0_ready = accept && !owner;
    bus.req1_ready = accept && owner;
`ifdef UART_TX_CHECKSUM_EN
    uart_tx_start  = accept || state == CHK;
    dataToSend     = accept ? own_data : state == CHK ? chk : data_q;
    release_grant  = state == CHK_WAIT && uart_tx_done;
`else
    uart_tx_start  = accept;
    dataToSend     = accept ? own_data : data_q;
    release_grant  = frame_end;
`endif
  end

  // frame bookkeeping: owner, held byte, byte count, round-robin pointer, checksum
  always_ff @(posedge clk or negedge uart_reset_n)
    if (!uart_reset_n) begin
      grant       <= 2'b00;
      owner       <= 1'b0;
      last_served <= 1'b1;
      last_q      <= 1'b0;
      count       <= 8'd0;
      data_q      <= '0;
`ifdef UART_TX_CHECKSUM_EN
      chk         <= '0;
`endif
    end else begin
      if (state == IDLE && |arb) begin
        grant <= arb;
        owner <= arb[1];
        count <= 8'd0;
`ifdef UART_TX_CHECKSUM_EN
        chk   <= '0;
`endif
      end
      if (accept) begin
        data_q <= own_data;
        last_q <= own_last;
        count  <= count + 8'd1;
`ifdef UART_TX_CHECKSUM_EN
        chk    <= chk ^ own_data;
`endif
      end
`ifdef UART_TX_CHECKSUM_EN
      if (state == CHK) data_q <= chk;
`endif
      if (frame_end) last_served <= owner;
      if (release_grant) grant <= 2'b00;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a frame-level model
module tb_uart_tx_arbiter;
  localparam int FM = 4;

  logic       clk = 1'b0;
  logic       uart_reset_n = 1'b0;
  logic       uart_tx_done = 1'b0;
  logic       uart_tx_start, busy;
  logic [7:0] dataToSend;
  logic [1:0] grant;

  uart_tx_arbiter_if #(.DBIT(8)) bus ();

  uart_tx_arbiter #(.DBIT(8), .FRAME_MAX(FM)) dut (
    .clk(clk),
    .uart_reset_n(uart_reset_n),
    .bus(bus.slave),
    .dataToSend(dataToSend),
    .uart_tx_start(uart_tx_start),
    .uart_tx_done(uart_tx_done),
    .grant(grant),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0, cyc = 0;
  logic [8:0] q0[$], q1[$];
  logic [9:0] starts[$], exp_q[$];
  int         st_cyc[$], dn_cyc[$];
  bit         en0 = 0, en1 = 0, pop0 = 0, pop1 = 0;
  int         tx_cnt = 0, tx_min = 1, tx_max = 4, v0_cyc = -100, r0_cnt = 0, r1_cnt = 0;
  logic [7:0] tx_hold = 8'h00;

  // requester drivers, transmitter model and output monitor
  initial begin
    bus.req0_valid = 0; bus.req0_data = 0; bus.req0_last = 0;
    bus.req1_valid = 0; bus.req1_data = 0; bus.req1_last = 0;
    forever begin
      @(negedge clk);
      if (uart_tx_start) begin
        starts.push_back({grant, dataToSend});
        st_cyc.push_back(cyc);
        tx_hold = dataToSend;
        tx_cnt = int'($urandom_range(tx_max, tx_min));
      end else if (tx_cnt > 0) begin
        checks++;
        if (dataToSend !== tx_hold) begin
          errors++;
          $display("FAIL data_hold: dataToSend=%h required %h", dataToSend, tx_hold);
        end
      end
      pop0 = bus.req0_ready;
      pop1 = bus.req1_ready;
      r0_cnt += int'(pop0);
      r1_cnt += int'(pop1);
      if (pop0 || pop1) begin
        checks++;
        if ((pop0 && grant !== 2'b01) || (pop1 && grant !== 2'b10)) begin
          errors++;
          $display("FAIL ready_owner: ready=%b%b grant=%b", pop1, pop0, grant);
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pop0 && q0.size() > 0) void'(q0.pop_front());
      if (pop1 && q1.size() > 0) void'(q1.pop_front());
      uart_tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          uart_tx_done = 1'b1;
          dn_cyc.push_back(cyc);
        end
      end
      if (en0 && q0.size() > 0 && !bus.req0_valid) v0_cyc = cyc;
      bus.req0_valid = en0 && q0.size() > 0;
      bus.req0_data  = q0.size() > 0 ? q0[0][7:0] : 8'h00;
      bus.req0_last  = q0.size() > 0 ? q0[0][8] : 1'b0;
      bus.req1_valid = en1 && q1.size() > 0;
      bus.req1_data  = q1.size() > 0 ? q1[0][7:0] : 8'h00;
      bus.req1_last  = q1.size() > 0 ? q1[0][8] : 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // frame-level reference: both requesters continuously offer their queued frames
  task automatic build_exp();
    logic [8:0] a[$], b[$], w;
    logic [7:0] x;
    logic [1:0] g;
    bit prev, pick;
    int n;
    a = q0;
    b = q1;
    prev = 1'b1;
    exp_q.delete();
    while (a.size() > 0 || b.size() > 0) begin
      pick = (a.size() > 0 && b.size() > 0) ? !prev : (a.size() == 0);
      g = pick ? 2'b10 : 2'b01;
      x = 8'h00;
      n = 0;
      do begin
        w = pick ? b.pop_front() : a.pop_front();
        exp_q.push_back({g, w[7:0]});
        x ^= w[7:0];
        n++;
      end while (!w[8] && n < FM && (pick ? b.size() : a.size()) > 0);
`ifdef UART_TX_CHECKSUM_EN
      exp_q.push_back({g, x});
`endif
      prev = pick;
    end
  endtask

  task automatic do_reset();
    uart_reset_n = 1'b0;
    en0 = 0; en1 = 0;
    q0.delete(); q1.delete();
    tx_cnt = 0; uart_tx_done = 1'b0; pop0 = 0; pop1 = 0;
    tx_min = 1; tx_max = 4;
    repeat (2) @(posedge clk);
    #2;
    starts.delete(); st_cyc.delete(); dn_cyc.delete();
    r0_cnt = 0; r1_cnt = 0;
    uart_reset_n = 1'b1;
  endtask

  task automatic wait_starts(input int n);
    int b = 0;
    while (starts.size() < n && b < 3000) begin
      @(posedge clk);
      b++;
    end
    checks++;
    if (starts.size() < n) begin
      errors++;
      $display("FAIL wait_starts: got %0d starts, required %0d", starts.size(), n);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    do begin
      @(posedge clk);
      #2;
      b++;
    end while ((busy || tx_cnt > 0) && b < 3000);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    uart_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks += 5;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: %b required 00", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    if (uart_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: %b required 0", uart_tx_start); end
    if (dataToSend !== 8'h00) begin errors++; $display("FAIL reset_data: %h required 00", dataToSend); end
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: %b%b required 00", bus.req1_ready, bus.req0_ready);
    end
    do_reset();
    repeat (5) @(posedge clk);
    #2;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: %b required 0", busy); end
    if (starts.size() != 0) begin errors++; $display("FAIL idle_start: %0d starts required 0", starts.size()); end
  endtask

  task automatic test_single_frame();
    do_reset();
    q0.push_back(9'h041); q0.push_back(9'h142);
    build_exp();
    en0 = 1;
    wait_starts(exp_q.size());
    wait_idle();
    checks++;
    if (starts.size() != exp_q.size()) begin errors++; $display("FAIL single_count: %0d required %0d", starts.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if ((i < starts.size() ? starts[i] : 10'h3ff) !== exp_q[i]) begin
        errors++; $display("FAIL single_byte%0d: %h required %h", i, i < starts.size() ? starts[i] : 10'h3ff, exp_q[i]);
      end
    end
    checks += 4;
    if (starts.size() > 0 && starts[0] !== {2'b01, 8'h41}) begin errors++; $display("FAIL single_first: %h required 141", starts[0]); end
    if (st_cyc.size() > 0 && st_cyc[0] - v0_cyc != 1) begin errors++; $display("FAIL latency: %0d cycles required 1", st_cyc[0] - v0_cyc); end
    if (st_cyc.size() > 1 && dn_cyc.size() > 0 && st_cyc[1] - dn_cyc[0] != 1) begin
      errors++; $display("FAIL gap: %0d cycles required 1", st_cyc[1] - dn_cyc[0]);
    end
    if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_end: %b required 00", grant); end
  endtask

  task automatic test_round_robin();
    do_reset();
    q0.push_back(9'h010); q0.push_back(9'h111); q0.push_back(9'h112);
    q1.push_back(9'h020); q1.push_back(9'h121); q1.push_back(9'h122);
    build_exp();
    en0 = 1; en1 = 1;
    wait_starts(exp_q.size());
    wait_idle();
    checks += 2;
    if (starts.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: %0d required %0d", starts.size(), exp_q.size()); end
    if (starts.size() > 0 && starts[0] !== {2'b01, 8'h10}) begin errors++; $display("FAIL rr_first: %h required 110", starts[0]); end
    foreach (exp_q[i]) begin
      checks++;
      if ((i < starts.size() ? starts[i] : 10'h3ff) !== exp_q[i]) begin
        errors++; $display("FAIL rr_byte%0d: %h required %h", i, i < starts.size() ? starts[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_frame_lock();
    do_reset();
`ifdef UART_TX_CHECKSUM_EN
    exp_q = '{10'h231, 10'h232, 10'h233, 10'h230, 10'h101, 10'h101};
`else
    exp_q = '{10'h231, 10'h232, 10'h233, 10'h101};
`endif
    q1.push_back(9'h031); q1.push_back(9'h032); q1.push_back(9'h133);
    q0.push_back(9'h101);
    en1 = 1;
    @(posedge clk);
    #2;
    en0 = 1;
    wait_starts(1);
    en1 = 0;
    repeat (8) @(posedge clk);
    #2;
    checks += 4;
    if (r0_cnt != 0) begin errors++; $display("FAIL lock_ready0: %0d pulses required 0", r0_cnt); end
    if (starts.size() != 1) begin errors++; $display("FAIL lock_starts: %0d required 1", starts.size()); end
    if (grant !== 2'b10) begin errors++; $display("FAIL lock_grant: %b required 10", grant); end
    if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy: %b required 1", busy); end
    en1 = 1;
    wait_starts(exp_q.size());
    wait_idle();
    checks += 2;
    if (starts.size() != exp_q.size()) begin errors++; $display("FAIL lock_count: %0d required %0d", starts.size(), exp_q.size()); end
    if (r0_cnt != 1) begin errors++; $display("FAIL lock_ready0_total: %0d required 1", r0_cnt); end
    foreach (exp_q[i]) begin
      checks++;
      if ((i < starts.size() ? starts[i] : 10'h3ff) !== exp_q[i]) begin
        errors++; $display("FAIL lock_byte%0d: %h required %h", i, i < starts.size() ? starts[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_frame_max();
    do_reset();
`ifdef UART_TX_CHECKSUM_EN
    exp_q = '{10'h150, 10'h151, 10'h152, 10'h153, 10'h100, 10'h260, 10'h260, 10'h154, 10'h155};
`else
    exp_q = '{10'h150, 10'h151, 10'h152, 10'h153, 10'h260, 10'h154, 10'h155};
`endif
    for (int i = 0; i < 6; i++) q0.push_back(9'(8'h50 + i));
    en0 = 1;
    wait_starts(1);
    q1.push_back(9'h160);
    en1 = 1;
    wait_starts(exp_q.size());
    repeat (12) @(posedge clk);
    #2;
    checks += 3;
    if (starts.size() != exp_q.size()) begin errors++; $display("FAIL fmax_count: %0d required %0d", starts.size(), exp_q.size()); end
    if (grant !== 2'b01) begin errors++; $display("FAIL fmax_grant: %b required 01", grant); end
    if (busy !== 1'b1) begin errors++; $display("FAIL fmax_busy: %b required 1", busy); end
    foreach (exp_q[i]) begin
      checks++;
      if ((i < starts.size() ? starts[i] : 10'h3ff) !== exp_q[i]) begin
        errors++; $display("FAIL fmax_byte%0d: %h required %h", i, i < starts.size() ? starts[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_min = 6; tx_max = 6;
    q0.push_back(9'h070); q0.push_back(9'h171);
    en0 = 1;
    wait_starts(1);
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: %b required 1", busy); end
    uart_reset_n = 1'b0;
    en0 = 0; q0.delete(); tx_cnt = 0;
    #1;
    checks += 3;
    if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant: %b required 00", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: %b required 0", busy); end
    if (uart_tx_start !== 1'b0) begin errors++; $display("FAIL mid_start: %b required 0", uart_tx_start); end
    @(posedge clk);
    #2;
    uart_reset_n = 1'b1;
    tx_min = 1; tx_max = 4;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (starts.size() != 1) begin errors++; $display("FAIL mid_no_resume: %0d starts required 1", starts.size()); end
    q0.push_back(9'h172);
    en0 = 1;
    wait_starts(2);
    wait_idle();
    checks++;
    if (starts.size() > 1 && starts[1] !== {2'b01, 8'h72}) begin errors++; $display("FAIL mid_new_frame: %h required 172", starts[1]); end
  endtask

  task automatic test_checksum();
    do_reset();
    q0.push_back(9'h012); q0.push_back(9'h134);
    en0 = 1;
`ifdef UART_TX_CHECKSUM_EN
    wait_starts(3);
    wait_idle();
    checks += 3;
    if (starts.size() != 3) begin errors++; $display("FAIL chk_count: %0d required 3", starts.size()); end
    if (starts.size() > 2 && starts[2] !== {2'b01, 8'h26}) begin errors++; $display("FAIL chk_value: %h required 126", starts[2]); end
`else
    wait_starts(2);
    wait_idle();
    checks += 3;
    if (starts.size() != 2) begin errors++; $display("FAIL chk_count: %0d required 2", starts.size()); end
    if (starts.size() > 1 && starts[1] !== {2'b01, 8'h34}) begin errors++; $display("FAIL chk_last: %h required 134", starts[1]); end
`endif
    if (r0_cnt != 2) begin errors++; $display("FAIL chk_ready: %0d pulses required 2", r0_cnt); end
  endtask

  task automatic test_random();
    int len, total;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      tx_max = 1 + it;
      total = 0;
      for (int f = 0; f < 3; f++) begin
        len = int'($urandom_range(6, 1));
        for (int k = 0; k < len; k++) q0.push_back({k == len - 1, 8'($urandom)});
        total += len;
        len = int'($urandom_range(6, 1));
        for (int k = 0; k < len; k++) q1.push_back({k == len - 1, 8'($urandom)});
        total += len;
      end
      build_exp();
      en0 = 1; en1 = 1;
      wait_starts(exp_q.size());
      wait_idle();
      checks += 2;
      if (starts.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: %0d required %0d", it, starts.size(), exp_q.size()); end
      if (r0_cnt + r1_cnt != total) begin errors++; $display("FAIL rand%0d_ready: %0d pulses required %0d", it, r0_cnt + r1_cnt, total); end
      foreach (exp_q[i]) begin
        checks++;
        if ((i < starts.size() ? starts[i] : 10'h3ff) !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_byte%0d: %h required %h", it, i, i < starts.size() ? starts[i] : 10'h3ff, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_frame_lock();
    test_frame_max();
    test_reset_mid();
    test_checksum();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DBIT, default 8: data byte width, matching the UART transmitter.
REQ-002 Parameter FRAME_MAX, default 64: maximum bytes per granted frame before forced release; range 1..255.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 uart_reset_n  in  1  asynchronous, active-low reset.
REQ-005 req0_valid  in  1  requester 0 has a byte on req0_data.
REQ-006 req0_data  in  DBIT  requester 0 byte.
REQ-007 req0_last  in  1  qualifies req0_data as the final byte of the frame.
REQ-008 req0_ready  out  1  one-cycle pulse: req0_data is consumed this cycle.
REQ-009 req1_valid, req1_data, req1_last, req1_ready: same as REQ-005..008, for requester 1.
REQ-010 dataToSend  out  DBIT  byte to the transmitter; held stable from start until done.
REQ-011 uart_tx_start  out  1  one-cycle pulse that launches the transmitter.
REQ-012 uart_tx_done  in  1  one-cycle pulse from the transmitter at end of stop bit.
REQ-013 grant  out  2  one-hot current frame owner; 00 when idle.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT, and, with the macro enabled, CHK and CHK_WAIT.
REQ-016 IDLE: if any reqN_valid, next cycle -> SEND with grant set; owner is chosen by the round-robin pointer.
REQ-017 Round-robin: with both valid in IDLE, grant goes to the requester not served by the previous frame; after reset, requester 0 wins.
REQ-018 SEND: if owner valid, in the same cycle register the owner's data into dataToSend, pulse uart_tx_start and owner ready, increment byte count, -> WAIT.
REQ-019 SEND with owner valid low: remain in SEND, grant held; the other requester stays blocked (frame lock).
REQ-020 Non-owner ready SHALL never assert.
REQ-021 WAIT: ignore requests until uart_tx_done.
REQ-022 WAIT with done, when the sent byte had last=1 or count==FRAME_MAX: -> IDLE, or -> CHK when the macro is enabled.
REQ-023 WAIT with done, otherwise: -> SEND.
REQ-024 Minimum latency SHALL be 1 cycle from valid in IDLE to uart_tx_start.
REQ-025 Minimum gap SHALL be 1 cycle from uart_tx_done to the next uart_tx_start.
REQ-026 uart_tx_done outside WAIT or CHK_WAIT SHALL be ignored.
REQ-027 Byte count SHALL be 8 bits, cleared at frame start, and never wrap (forced release at FRAME_MAX).
REQ-028 On frame end, the rr pointer SHALL update, grant clear to 00 on entry to IDLE, and busy drop the same cycle.

Reset
REQ-029 Asserting uart_reset_n low at any time, including mid-frame, SHALL force IDLE immediately.
REQ-030 Reset values: grant=00, busy=0, uart_tx_start=0, ready=0, dataToSend=0, count=0, rr pointer selects requester 0, checksum=0.
REQ-031 The partially sent frame SHALL NOT be resumed after reset.

Configuration
REQ-032 Macro UART_TX_CHECKSUM_EN defined: accumulate the XOR of all frame bytes.
REQ-033 CHK state: drive the XOR onto dataToSend, pulse uart_tx_start, no ready pulse, -> CHK_WAIT.
REQ-034 CHK_WAIT: on done -> IDLE; grant is held until then.
REQ-035 Macro undefined: no CHK states and no accumulator; frame ends directly to IDLE.

Structure
REQ-036 Shared package uart_pkg SHALL hold the state enum, DBIT, and the FRAME_MAX default.
REQ-037 One sub-module, rr_arbiter2: two requests plus last-served pointer -> one-hot grant; combinational, pointer kept in the parent.

Verification
REQ-038 Req0 frame 0x41,0x42(last) alone -> two starts with 0x41 then 0x42, each after done, grant=01, then idle.
REQ-039 Both valid in IDLE after reset -> req0 served first, then req1 frame, then req0 again when both re-request.
REQ-040 Req1 drops valid mid-frame while req0 valid -> req0 ready never pulses until req1 sends last.
REQ-041 FRAME_MAX=4, req0 streams 6 bytes with no last -> release after 4th done; req1 (waiting) granted next.
REQ-042 Reset pulse during WAIT -> grant=00, busy=0 in the same cycle; no further start until new valid.
REQ-043 With UART_TX_CHECKSUM_EN, frame 0x12,0x34(last) -> third start with dataToSend=0x26, no ready pulse.
